// File: rtl/dsm_quantizer_if.sv
// Quantizer-side bundle: integrator sample/strobe in, DSD bit, feedback and loop status out.
// The master is the modulator datapath that drives the strobe; the slave is the quantizer.
interface dsm_quantizer_if #(
    parameter int PCM_Bit_Length = 32
);
    logic                             CE_I;
    logic signed [PCM_Bit_Length+1:0] DATA_I;
    logic                             OVL_CLR_I;
    logic                             DSD_O;
    logic                             DSD_VALID_O;
    logic signed [PCM_Bit_Length:0]   FB_O;
    logic                             CLR_O;
    logic                             OVL_O;

    modport master (
        output CE_I, DATA_I, OVL_CLR_I,
        input  DSD_O, DSD_VALID_O, FB_O, CLR_O, OVL_O
    );

    modport slave (
        input  CE_I, DATA_I, OVL_CLR_I,
        output DSD_O, DSD_VALID_O, FB_O, CLR_O, OVL_O
    );
endinterface

// File: rtl/dsm_quantizer.sv
// One-bit quantizer and loop supervisor of the delta-sigma modulator: emits a DSD bit and
// full-scale feedback per strobe, forcing 0x69 silence at start-up and after overload.
module dsm_quantizer #(
    parameter int PCM_Bit_Length = 32,
    parameter int OVL_LIMIT      = 64,
    parameter int MUTE_SAMPLES   = 1024
) (
    input  logic           MCLK_I,
    input  logic           RESET_NI,
    dsm_quantizer_if.slave q
);
    localparam int N  = PCM_Bit_Length;
    localparam int MW = $clog2(MUTE_SAMPLES);
    localparam int RW = $clog2(OVL_LIMIT + 1);

    localparam logic [7:0]        SIL_PAT = 8'h69;
    localparam logic signed [N:0] FB_POS  = {2'b01, {(N-1){1'b0}}};
    localparam logic signed [N:0] FB_NEG  = {2'b11, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        MUTE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t            state;
    logic [MW-1:0]     mute_cnt;
    logic [RW-1:0]     run_cnt;
    logic [RW-1:0]     run_nxt;
    logic [2:0]        sil_idx;
    logic              prev_bit;
    logic              qbit;
    logic              dsd_q;
    logic              vld_q;
    logic signed [N:0] fb_q;
    logic              clr_q;
    logic              ovl_q;

    // Only the sign of the integrator output matters to a one-bit quantizer.
    logic unused_data;
    assign unused_data = ^q.DATA_I[N:0];

    assign qbit = ~q.DATA_I[N+1];

    always_comb begin
        run_nxt = run_cnt;
        if (run_cnt == '0 || qbit != prev_bit)
            run_nxt = RW'(1);
        else if (run_cnt != RW'(OVL_LIMIT))
            run_nxt = run_cnt + 1'b1;
    end

    always_ff @(posedge MCLK_I) begin
        if (!RESET_NI) begin
            state    <= MUTE;
            mute_cnt <= '0;
            run_cnt  <= '0;
            sil_idx  <= '0;
            prev_bit <= 1'b0;
            dsd_q    <= 1'b0;
            vld_q    <= 1'b0;
            fb_q     <= '0;
            clr_q    <= 1'b1;
            ovl_q    <= 1'b0;
        end else begin
            vld_q <= q.CE_I;
            // Overload set below is ordered after this, so a same-cycle set wins.
            if (q.OVL_CLR_I)
                ovl_q <= 1'b0;
            if (q.CE_I) begin
                case (state)
                    MUTE: begin
                        dsd_q   <= SIL_PAT[3'd7 - sil_idx];
                        fb_q    <= '0;
                        sil_idx <= sil_idx + 3'd1;
                        if (mute_cnt == MW'(MUTE_SAMPLES - 1)) begin
                            state    <= RUN;
                            clr_q    <= 1'b0;
                            mute_cnt <= '0;
                            run_cnt  <= '0;
                        end else begin
                            mute_cnt <= mute_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        dsd_q    <= qbit;
                        fb_q     <= qbit ? FB_POS : FB_NEG;
                        prev_bit <= qbit;
                        if (run_nxt == RW'(OVL_LIMIT)) begin
                            ovl_q   <= 1'b1;
                            state   <= RECOVER;
                            clr_q   <= 1'b1;
                            sil_idx <= '0;
                            run_cnt <= '0;
                        end else begin
                            run_cnt <= run_nxt;
                        end
                    end
                    RECOVER: begin
                        dsd_q   <= SIL_PAT[3'd7 - sil_idx];
                        fb_q    <= '0;
                        sil_idx <= sil_idx + 3'd1;
                        // The 3-bit index doubles as the 8-strobe recovery counter.
                        if (sil_idx == 3'd7) begin
                            state   <= RUN;
                            clr_q   <= 1'b0;
                            run_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= MUTE;
                        mute_cnt <= '0;
                        sil_idx  <= '0;
                        clr_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign q.DSD_O       = dsd_q;
    assign q.DSD_VALID_O = vld_q;
    assign q.FB_O        = fb_q;
    assign q.CLR_O       = clr_q;
    assign q.OVL_O       = ovl_q;
endmodule

// File: tb/tb_dsm_quantizer.sv
// Randomized and directed bench for dsm_quantizer against a sample-level reference model.
module tb_dsm_quantizer;
    localparam int N            = 16;
    localparam int OVL_LIMIT    = 4;
    localparam int MUTE_SAMPLES = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsm_quantizer_if #(.PCM_Bit_Length(N)) bus ();

    dsm_quantizer #(
        .PCM_Bit_Length(N),
        .OVL_LIMIT     (OVL_LIMIT),
        .MUTE_SAMPLES  (MUTE_SAMPLES)
    ) dut (
        .MCLK_I  (clk),
        .RESET_NI(rst_n),
        .q       (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: silence is "strobes of silence still owed"; overload is judged by
    // looking back over the bits emitted since the loop last (re)started.
    int sil_left;
    int sil_pos;
    bit hist[$];
    bit m_dsd, m_vld, m_clr, m_ovl;
    int m_fb;

    function automatic void model_reset();
        sil_left = MUTE_SAMPLES;
        sil_pos  = 0;
        hist.delete();
        m_dsd = 0; m_vld = 0; m_fb = 0; m_clr = 1; m_ovl = 0;
    endfunction

    function automatic void model_cycle(bit ce, logic signed [N+1:0] d, bit oc);
        bit [7:0] pat = 8'h69;
        bit b;
        int run;
        m_vld = ce;
        if (oc) m_ovl = 0;
        if (!ce) return;
        if (sil_left > 0) begin
            m_dsd = pat[7 - (sil_pos % 8)];
            m_fb  = 0;
            sil_pos++;
            sil_left--;
            m_clr = (sil_left > 0);
        end else begin
            b     = (d >= 0);
            m_dsd = b;
            m_fb  = b ? (1 << (N-1)) : -(1 << (N-1));
            hist.push_back(b);
            if (hist.size() > OVL_LIMIT) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != b) break;
                run++;
            end
            if (run >= OVL_LIMIT) begin
                m_ovl    = 1;
                sil_left = 8;
                sil_pos  = 0;
                hist.delete();
                m_clr    = 1;
            end else begin
                m_clr = 0;
            end
        end
    endfunction

    string phase = "reset";

    task automatic step(input bit ce, input logic signed [N+1:0] d, input bit oc, input bit rs);
        logic [N:0] efb;
        @(negedge clk);
        rst_n         = rs;
        bus.CE_I      = ce;
        bus.DATA_I    = d;
        bus.OVL_CLR_I = oc;
        @(posedge clk);
        if (!rs) model_reset();
        else     model_cycle(ce, d, oc);
        #1;
        efb = m_fb[N:0];
        chk({phase, ".dsd"}, 64'(bus.DSD_O), 64'(m_dsd));
        chk({phase, ".vld"}, 64'(bus.DSD_VALID_O), 64'(m_vld));
        chk({phase, ".fb"},  {47'b0, bus.FB_O}, {47'b0, efb});
        chk({phase, ".clr"}, 64'(bus.CLR_O), 64'(m_clr));
        chk({phase, ".ovl"}, 64'(bus.OVL_O), 64'(m_ovl));
    endtask

    task automatic strobe(input logic signed [N+1:0] d, input int max_gap);
        step(1'b1, d, 1'b0, 1'b1);
        repeat ($urandom_range(0, max_gap)) step(1'b0, d, 1'b0, 1'b1);
    endtask

    initial begin
        logic signed [N+1:0] mn;
        logic signed [N+1:0] d;
        bit trend;
        bit ce, oc, rs;
        mn = '0;
        mn[N+1] = 1'b1;
        bus.CE_I = 0; bus.DATA_I = '0; bus.OVL_CLR_I = 0;
        model_reset();

        repeat (3) step(1'b1, 18'sd7, 1'b0, 1'b0);

        phase = "mute";
        for (int i = 0; i < MUTE_SAMPLES; i++) strobe(18'sd1000, 2);
        phase = "first_run";
        strobe(18'sd1000, 1);

        phase = "alt";
        for (int i = 0; i < 20; i++) strobe((i % 2) ? -18'sd5 : 18'sd5, 1);

        phase = "ovl";
        for (int i = 0; i < OVL_LIMIT; i++) strobe(-18'sd1, 1);
        phase = "recover";
        for (int i = 0; i < 8; i++) strobe(-18'sd1, 1);
        phase = "fresh";
        for (int i = 0; i < OVL_LIMIT - 1; i++) strobe(-18'sd1, 0);
        phase = "ovl_clr";
        step(1'b0, -18'sd1, 1'b1, 1'b1);
        step(1'b0, -18'sd1, 1'b0, 1'b1);
        phase = "set_wins";
        step(1'b1, -18'sd1, 1'b1, 1'b1);
        step(1'b0, -18'sd1, 1'b0, 1'b1);

        phase = "rst_recover";
        strobe(-18'sd1, 0);
        strobe(-18'sd1, 0);
        step(1'b1, 18'sd9, 1'b0, 1'b0);
        phase = "remute";
        for (int i = 0; i < MUTE_SAMPLES; i++) strobe(18'sd9, 0);

        phase = "edge";
        strobe(18'sd0, 1);
        strobe(mn, 1);
        strobe(18'sd0, 1);

        phase = "rand";
        trend = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) trend = ~trend;
            d = 18'($urandom);
            d[N+1] = ~trend;
            ce = ($urandom_range(0, 2) != 0);
            oc = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 599) != 0);
            step(ce, d, oc, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsm_quantizer.md
# dsm_quantizer

One-bit quantizer and loop-control stage of the PCM-to-DSD delta-sigma modulator. It sits directly downstream of the integrator. On each DSD sample strobe it:
- samples the integrator output and emits one DSD bit;
- returns the matching full-scale feedback word to the delta stage;
- supervises the loop, forcing DSD silence at start-up and after an overload (long run of identical bits), and raising an integrator clear request while doing so.

## Interface
Parameters:
- PCM_Bit_Length, 32, parallel PCM word length N; DATA_I is N+2 bits, FB_O is N+1 bits
- OVL_LIMIT, 64, consecutive identical DSD bits that declare overload; legal 2..65535
- MUTE_SAMPLES, 1024, silence strobes after reset; multiple of 8, at least 8

Ports:
- MCLK_I  in  1  clock; one clock, all logic on rising edge
- RESET_NI  in  1  reset; synchronous, active-low
- CE_I  in  1  DSD sample strobe, one MCLK_I cycle wide
- DATA_I  in  signed [N+1:0]  integrator output
- OVL_CLR_I  in  1  clears sticky OVL_O
- DSD_O  out  1  DSD bit, held between strobes
- DSD_VALID_O  out  1  one-cycle pulse when DSD_O updates
- FB_O  out  signed [N:0]  feedback word to the delta stage
- CLR_O  out  1  integrator state clear request, level
- OVL_O  out  1  sticky overload flag

## Operation
- States: MUTE, RUN, RECOVER. Reset enters MUTE. Nothing changes on cycles with CE_I=0 except the OVL_O clear.
- Quantize (RUN only):
  - bit = 1 when DATA_I >= 0 (MSB=0), else bit = 0.
  - FB_O = +2^(N-1) for bit 1, -2^(N-1) for bit 0, sign-extended to N+1 bits.
  - DSD_O = bit.
- Silence (MUTE, RECOVER):
  - DSD_O walks the pattern 0x69 MSB-first (0,1,1,0,1,0,0,1) using a 3-bit index. The index resets to 0 on entry to either state.
  - FB_O = 0 and CLR_O = 1. DATA_I is ignored.
- MUTE:
  - A strobe counter runs from 0.
  - On the MUTE_SAMPLES-th strobe, that strobe still outputs silence, then the state moves to RUN.
  - The run counter is 0 on entry to RUN.
- RUN run-length tracking:
  - Keep prev_bit and run_cnt; run_cnt saturates at OVL_LIMIT.
  - On a strobe, if run_cnt=0 or bit differs from prev_bit, run_cnt=1; otherwise run_cnt+1.
  - When run_cnt reaches OVL_LIMIT:
    - that strobe's quantized bit is still output;
    - OVL_O is set, and the state moves to RECOVER on the same edge.
- RECOVER: exactly 8 silence strobes, then RUN with run_cnt=0.
- OVL_O stays set until an OVL_CLR_I cycle. If a set event and OVL_CLR_I occur in the same cycle, set wins.
- CLR_O = 1 in MUTE and RECOVER, 0 in RUN. It changes only on the strobe edge that changes the state.

## Timing
- Latency: DATA_I sampled on the CE_I=1 edge; DSD_O, FB_O and DSD_VALID_O are valid the following cycle.
- DSD_VALID_O is high exactly one cycle per strobe, in every state.
- Reset values:
  - DSD_O=0, DSD_VALID_O=0, FB_O=0, OVL_O=0, CLR_O=1;
  - state=MUTE, all counters 0.
- A CE_I coincident with RESET_NI=0 is ignored.
- Reset mid-RUN or mid-RECOVER: next cycle is MUTE with a full MUTE_SAMPLES count. OVL_O is cleared.
- Back-to-back strobes (CE_I high on consecutive cycles) are legal. Each is processed, with a one-cycle DSD_VALID_O pulse per strobe.
- Arithmetic is two's complement. No rounding or saturation is needed: the feedback magnitude fits in N+1 bits.

## Test plan
- Reset release, MUTE_SAMPLES=16, DATA_I=+1000, 16 strobes → DSD_O = 0,1,1,0,1,0,0,1 twice; FB_O=0; CLR_O=1. The 17th strobe → DSD_O=1, FB_O=+2^(N-1), CLR_O=0.
- RUN with N=16, DATA_I alternating +5/-5 per strobe → DSD_O 1,0,1,0…; FB_O = +32768/-32768 sign-extended; OVL_O stays 0; DSD_VALID_O one pulse per strobe, one cycle after CE_I.
- OVL_LIMIT=4, DATA_I held at -1 → 4 zero bits. On the 4th-bit edge, OVL_O=1 and CLR_O=1. Next 8 strobes output 0x69 silence, then RUN resumes with 0 bits and a fresh count.
- OVL_O set, OVL_CLR_I pulsed alone → OVL_O=0 the next cycle. OVL_CLR_I asserted in the same cycle as a new overload → OVL_O remains 1.
- RESET_NI low for one cycle during RECOVER, with CE_I high in that cycle → strobe ignored; all outputs at reset values; MUTE restarts and runs the full count.
- DATA_I = 0 exactly → bit 1; DATA_I = most negative N+2-bit value → bit 0, FB_O = -2^(N-1).
